o_feature_store: RTL and testbench

Output-side write-back unit for the CLP. It is the write counterpart of the input feature fetcher: it accepts scaled feature samples from the configurable data path and packs them into data-bus words. It then writes those words to external feature memory over an address/write-enable port with a ready handshake. When the programmed word count has been written, it reports completion to the top FSM. A store instruction from the instruction decoder starts it, and its done pulse is OR-ed into the FSM's execution-done input alongside the fetchers' done signals.

---
 rtl/o_store_pkg.sv | 31 +++
 rtl/o_word_fifo.sv | 64 ++++++
 rtl/o_feature_store.sv | 168 ++++++++++++++++
 tb/tb_o_feature_store.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/o_store_pkg.sv
`default_nettype none
// ============================================================================
// Module      : o_store_pkg
// Description : Shared definitions for the output feature store. Holds the
//               default widths (mirroring the network_para.vh values), the
//               FSM state encoding and the lane-count helper.
// Revision    : 1.0 - initial release
// ============================================================================
package o_store_pkg;

    // Default widths, tied to the network parameter header values
    localparam int c_FEATURE_WIDTH  = 8;
    localparam int c_SCALER_WIDTH   = 8;
    localparam int c_IN_WIDTH       = c_FEATURE_WIDTH + c_SCALER_WIDTH;
    localparam int c_DATA_BUS_WIDTH = 128;
    localparam int c_ADDR_WIDTH     = 16;
    localparam int c_FIFO_DEPTH     = 4;
    localparam int c_CNT_WIDTH      = 8;

    // FSM state encoding
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    // Number of samples packed into one bus word
    function automatic int calc_lanes(input int bus_width, input int in_width);
        return bus_width / in_width;
    endfunction

endpackage : o_store_pkg
`default_nettype wire

// File: rtl/o_word_fifo.sv
`default_nettype none
// ============================================================================
// Module      : o_word_fifo
// Description : Synchronous WIDTH x DEPTH word FIFO with a first-word
//               fall-through head. DEPTH must be a power of two (>= 2).
//               Pointers carry one extra wrap bit to tell full from empty.
// Ports       : clk     - clock (rising edge)
//               rst     - asynchronous active-low reset (empties the FIFO)
//               i_push  - write i_data this cycle (caller guarantees !o_full)
//               i_data  - word to write
//               i_pop   - drop the head this cycle (caller guarantees !o_empty)
//               o_head  - current head word, forced to 0 while empty
//               o_full  - FIFO holds DEPTH words
//               o_empty - FIFO holds no words
// Revision    : 1.0 - initial release
// ============================================================================
module o_word_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wptr;
    logic [c_AW:0]    r_rptr;

    // Storage needs no reset: the head is masked while the FIFO is empty
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wptr[c_AW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (i_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                     (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
    assign o_head  = o_empty ? '0 : r_mem[r_rptr[c_AW-1:0]];

endmodule : o_word_fifo
`default_nettype wire

// File: rtl/o_feature_store.sv
`default_nettype none
// ============================================================================
// Module      : o_feature_store
// Description : Output write-back unit. Packs scaled feature samples into
//               bus words (lane 0 = LSBs = first sample), buffers them in a
//               small word FIFO and writes them to external feature memory
//               at consecutive word addresses with a ready handshake.
//               Signals completion with a one-cycle store_done pulse.
// Ports       : clk             - clock (rising edge)
//               rst             - asynchronous active-low reset
//               store_enable    - start pulse (ignored unless idle)
//               dst_addr        - base word address, sampled on start
//               store_counter   - number of words to write, sampled on start
//               feature_in      - scaled feature sample
//               feature_valid   - feature_in valid
//               feature_ready   - sample accepted this cycle when valid
//               o_data_bus_port - write data (FIFO head)
//               o_feature_addr  - write address (base + words written)
//               o_feature_wr_en - write request, held until accepted
//               o_wr_ready      - memory accepts the current write
//               busy            - store in progress
//               store_done      - one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module o_feature_store
    import o_store_pkg::*;
#(
    parameter int IN_WIDTH       = c_IN_WIDTH,
    parameter int DATA_BUS_WIDTH = c_DATA_BUS_WIDTH,
    parameter int ADDR_WIDTH     = c_ADDR_WIDTH,
    parameter int FIFO_DEPTH     = c_FIFO_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      store_enable,
    input  logic [ADDR_WIDTH-1:0]     dst_addr,
    input  logic [c_CNT_WIDTH-1:0]    store_counter,
    input  logic [IN_WIDTH-1:0]       feature_in,
    input  logic                      feature_valid,
    output logic                      feature_ready,
    output logic [DATA_BUS_WIDTH-1:0] o_data_bus_port,
    output logic [ADDR_WIDTH-1:0]     o_feature_addr,
    output logic                      o_feature_wr_en,
    input  logic                      o_wr_ready,
    output logic                      busy,
    output logic                      store_done
);

    localparam int c_LANES  = calc_lanes(DATA_BUS_WIDTH, IN_WIDTH);
    localparam int c_LANE_W = (c_LANES > 1) ? $clog2(c_LANES) : 1;

    logic [1:0]                r_state;
    logic [1:0]                w_state_nxt;
    logic [c_LANE_W-1:0]       r_lane_cnt;
    logic [c_CNT_WIDTH-1:0]    r_words_packed;
    logic [c_CNT_WIDTH-1:0]    r_words_written;
    logic [c_CNT_WIDTH-1:0]    r_target;
    logic [ADDR_WIDTH-1:0]     r_base;
    logic [DATA_BUS_WIDTH-1:0] r_pack;
    logic [DATA_BUS_WIDTH-1:0] w_word;

    logic w_start;
    logic w_accept;
    logic w_lane_last;
    logic w_push;
    logic w_wr_hs;
    logic w_last_write;
    logic w_fifo_full;
    logic w_fifo_empty;

    assign w_start      = (r_state == c_ST_IDLE) && store_enable;
    assign feature_ready = (r_state == c_ST_RUN) && !w_fifo_full &&
                           (r_words_packed < r_target);
    assign w_accept     = feature_valid && feature_ready;
    assign w_lane_last  = (r_lane_cnt == c_LANE_W'(c_LANES - 1));
    assign w_push       = w_accept && w_lane_last;
    assign w_wr_hs      = o_feature_wr_en && o_wr_ready;
    assign w_last_write = ((r_words_written + 1'b1) == r_target);

    // Word being assembled with the incoming sample dropped into its lane,
    // so the final lane can be pushed on the same edge it is accepted.
    for (genvar g = 0; g < c_LANES; g++) begin : g_lane
        assign w_word[g*IN_WIDTH +: IN_WIDTH] =
            (r_lane_cnt == c_LANE_W'(g)) ? feature_in
                                         : r_pack[g*IN_WIDTH +: IN_WIDTH];
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (store_enable) begin
                    w_state_nxt = (store_counter == '0) ? c_ST_DONE : c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (w_wr_hs && w_last_write) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    assign busy       = (r_state != c_ST_IDLE);
    assign store_done = (r_state == c_ST_DONE);

    // ------------------------------------------- packer and address counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_base          <= '0;
            r_target        <= '0;
            r_lane_cnt      <= '0;
            r_words_packed  <= '0;
            r_words_written <= '0;
            r_pack          <= '0;
        end else if (w_start) begin
            r_base          <= dst_addr;
            r_target        <= store_counter;
            r_lane_cnt      <= '0;
            r_words_packed  <= '0;
            r_words_written <= '0;
        end else begin
            if (w_accept) begin
                r_pack <= w_word;
                if (w_lane_last) begin
                    r_lane_cnt     <= '0;
                    r_words_packed <= r_words_packed + 1'b1;
                end else begin
                    r_lane_cnt <= r_lane_cnt + 1'b1;
                end
            end
            if (w_wr_hs) begin
                r_words_written <= r_words_written + 1'b1;
            end
        end
    end

    // Address wraps naturally modulo 2^ADDR_WIDTH
    assign o_feature_addr  = r_base + ADDR_WIDTH'(r_words_written);
    assign o_feature_wr_en = !w_fifo_empty;

    o_word_fifo #(
        .WIDTH (DATA_BUS_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_word_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_word),
        .i_pop   (w_wr_hs),
        .o_head  (o_data_bus_port),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

endmodule : o_feature_store
`default_nettype wire

// File: tb/tb_o_feature_store.sv
`default_nettype none
// ============================================================================
// Module      : tb_o_feature_store
// Description : Self-checking bench for o_feature_store. Each store is
//               described as a transaction: a base address, a word count and
//               a random sample stream. Expected writes are word i at
//               base+i carrying samples 8i..8i+7 (sample 8i in the LSBs);
//               ready/wr_en/done behaviour is derived from word-level counts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_o_feature_store;

    localparam int IN_W  = 16;
    localparam int BUS   = 128;
    localparam int AW    = 16;
    localparam int DEPTH = 4;
    localparam int LANES = BUS / IN_W;

    logic            clk;
    logic            rst;
    logic            store_enable;
    logic [AW-1:0]   dst_addr;
    logic [7:0]      store_counter;
    logic [IN_W-1:0] feature_in;
    logic            feature_valid;
    logic            feature_ready;
    logic [BUS-1:0]  o_data_bus_port;
    logic [AW-1:0]   o_feature_addr;
    logic            o_feature_wr_en;
    logic            o_wr_ready;
    logic            busy;
    logic            store_done;

    int n_cmp = 0;
    int n_err = 0;

    logic [IN_W-1:0] samples[$];

    o_feature_store #(
        .IN_WIDTH       (IN_W),
        .DATA_BUS_WIDTH (BUS),
        .ADDR_WIDTH     (AW),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .store_enable    (store_enable),
        .dst_addr        (dst_addr),
        .store_counter   (store_counter),
        .feature_in      (feature_in),
        .feature_valid   (feature_valid),
        .feature_ready   (feature_ready),
        .o_data_bus_port (o_data_bus_port),
        .o_feature_addr  (o_feature_addr),
        .o_feature_wr_en (o_feature_wr_en),
        .o_wr_ready      (o_wr_ready),
        .busy            (busy),
        .store_done      (store_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [BUS-1:0] got, input logic [BUS-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected content of bus word w of the current store
    function automatic logic [BUS-1:0] exp_word(input int w);
        logic [BUS-1:0] v;
        v = '0;
        for (int l = 0; l < LANES; l++) begin
            v[l*IN_W +: IN_W] = samples[w*LANES + l];
        end
        return v;
    endfunction

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ready"}, feature_ready, 0);
        check_eq({tag, "_wr_en"}, o_feature_wr_en, 0);
        check_eq({tag, "_data"}, o_data_bus_port, 0);
        check_eq({tag, "_addr"}, o_feature_addr, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, store_done, 0);
    endtask

    // One store transaction. vpct/rpct: percent probability of valid/ready.
    // stall: hold o_wr_ready low until the FIFO is seen full.
    // inject_at: cycle of the run at which a spurious start pulse is issued.
    // abort_words: leave early after this many writes plus a partial word.
    task automatic run_store(input logic [AW-1:0] base, input int cnt,
                             input int vpct, input int rpct, input bit seq,
                             input bit stall, input int inject_at,
                             input int abort_words, output bit aborted);
        int acc, wr_idx, occ, cyc;
        bit released, prev_stall, done, exp_ready;
        logic [BUS-1:0] prev_data;
        logic [AW-1:0]  prev_addr;

        aborted = 1'b0;
        samples.delete();
        for (int i = 0; i < cnt * LANES; i++) begin
            samples.push_back(seq ? IN_W'(i + 1) : IN_W'($urandom));
        end

        @(negedge clk);
        store_enable  = 1'b1;
        dst_addr      = base;
        store_counter = 8'(cnt);
        feature_valid = 1'b0;
        o_wr_ready    = 1'b0;
        #1;
        check_eq("idle_before_start", busy, 0);

        @(negedge clk);
        store_enable  = 1'b0;
        dst_addr      = AW'($urandom);
        store_counter = 8'($urandom);

        if (cnt == 0) begin
            #1;
            check_eq("zero_done", store_done, 1);
            check_eq("zero_wr_en", o_feature_wr_en, 0);
            check_eq("zero_ready", feature_ready, 0);
            @(negedge clk);
            #1;
            check_eq("zero_busy_after", busy, 0);
            check_eq("zero_done_after", store_done, 0);
            return;
        end

        acc = 0; wr_idx = 0; cyc = 0;
        released = 1'b0; prev_stall = 1'b0; done = 1'b0;
        prev_data = '0; prev_addr = '0;

        while (!done && cyc < 5000) begin
            store_enable = (cyc == inject_at);
            if (cyc == inject_at) begin
                dst_addr      = AW'($urandom);
                store_counter = 8'($urandom_range(255, 1));
            end
            feature_valid = ($urandom_range(99) < vpct);
            feature_in    = (acc < cnt * LANES) ? samples[acc] : IN_W'($urandom);
            o_wr_ready    = (stall && !released) ? 1'b0 : ($urandom_range(99) < rpct);
            #1;

            occ       = acc / LANES - wr_idx;
            exp_ready = (acc / LANES < cnt) && (occ < DEPTH);
            check_eq("feature_ready", feature_ready, exp_ready);
            check_eq("wr_en", o_feature_wr_en, occ > 0);
            check_eq("busy_run", busy, 1);
            check_eq("done_early", store_done, 0);
            if (stall && occ == DEPTH) released = 1'b1;

            if (o_feature_wr_en && wr_idx < cnt) begin
                check_eq("wr_data", o_data_bus_port, exp_word(wr_idx));
                check_eq("wr_addr", o_feature_addr, AW'(base + AW'(wr_idx)));
                if (prev_stall) begin
                    check_eq("stall_data", o_data_bus_port, prev_data);
                    check_eq("stall_addr", o_feature_addr, prev_addr);
                end
            end
            prev_stall = o_feature_wr_en && !o_wr_ready;
            prev_data  = o_data_bus_port;
            prev_addr  = o_feature_addr;

            if (feature_valid && feature_ready) acc++;
            if (o_feature_wr_en && o_wr_ready) wr_idx++;
            if (wr_idx >= cnt) done = 1'b1;

            if (abort_words > 0 && wr_idx >= abort_words && (acc % LANES) >= 3) begin
                aborted = 1'b1;
                store_enable = 1'b0;
                return;
            end
            cyc++;
            @(negedge clk);
        end
        store_enable  = 1'b0;
        feature_valid = 1'b0;

        if (!done) begin
            check_eq("store_timeout_words", wr_idx, cnt);
            return;
        end
        #1;
        check_eq("done_pulse", store_done, 1);
        check_eq("done_busy", busy, 1);
        check_eq("done_wr_en", o_feature_wr_en, 0);
        check_eq("done_ready", feature_ready, 0);
        @(negedge clk);
        #1;
        check_eq("busy_after_done", busy, 0);
        check_eq("done_single", store_done, 0);
    endtask

    initial begin
        bit ab;
        rst           = 1'b0;
        store_enable  = 1'b0;
        dst_addr      = '0;
        store_counter = '0;
        feature_in    = '0;
        feature_valid = 1'b0;
        o_wr_ready    = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b1;

        // Single word, sequential samples 1..8
        run_store(16'h0100, 1, 100, 100, 1'b1, 1'b0, -1, 0, ab);
        // Backpressure until FIFO full
        run_store(16'h2000, 6, 100, 100, 1'b0, 1'b1, -1, 0, ab);
        // Address wrap
        run_store(16'hFFFF, 2, 80, 70, 1'b0, 1'b0, -1, 0, ab);
        // Zero count
        run_store(16'h1234, 0, 100, 100, 1'b0, 1'b0, -1, 0, ab);
        // Spurious start pulse during a run
        run_store(16'h0300, 3, 60, 60, 1'b0, 1'b0, 5, 0, ab);

        // Reset after 3 words and a partial word
        run_store(16'h0400, 6, 100, 100, 1'b0, 1'b0, -1, 3, ab);
        check_eq("abort_reached", ab, 1);
        rst = 1'b0;
        #1;
        check_all_zero("abort");
        @(negedge clk);
        #1;
        check_eq("abort_no_done", store_done, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("abort_idle_done", store_done, 0);
        check_eq("abort_idle_wr_en", o_feature_wr_en, 0);
        run_store(16'h0500, 1, 90, 90, 1'b0, 1'b0, -1, 0, ab);

        // Randomized stores
        for (int k = 0; k < 8; k++) begin
            run_store(AW'($urandom), $urandom_range(10, 1), $urandom_range(100, 30),
                      $urandom_range(100, 20), 1'b0, 1'b0, -1, 0, ab);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_o_feature_store
`default_nettype wire
